// File: rtl/door_pkg.sv
// Shared types and constants for the elevator door sequencer.
//
// door_state_t : 2-bit door state encoding, as seen on the door_state output
//                (0=CLOSED, 1=OPENING, 2=OPEN, 3=CLOSING).
// REOPEN_W     : width of the reversal counter.
package door_pkg;

    typedef enum logic [1:0] {
        DOOR_CLOSED  = 2'd0,
        DOOR_OPENING = 2'd1,
        DOOR_OPEN    = 2'd2,
        DOOR_CLOSING = 2'd3
    } door_state_t;

    localparam int unsigned REOPEN_W = 4;

endpackage

// File: rtl/door_tick_gen.sv
// Free-running prescaler that produces a one-cycle tick every TICK_DIV clocks.
// The counter runs 0..TICK_DIV-1; tick_o is high while it sits at TICK_DIV-1,
// after which it wraps to 0. TICK_DIV=1 gives a tick on every cycle.
//
// Ports:
//   clk          in   system clock
//   button_reset in   asynchronous, active-high reset (counter to 0)
//   tick_o       out  single-cycle tick
module door_tick_gen #(
    parameter int unsigned TICK_DIV = 4
) (
    input  logic clk,
    input  logic button_reset,
    output logic tick_o
);

    // Keep at least one bit so TICK_DIV=1 still elaborates.
    localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TICK_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == CntLast);

    always_comb begin
        cnt_d = tick_o ? '0 : cnt_q + CntW'(1);
    end

    always_ff @(posedge clk or posedge button_reset) begin
        if (button_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/door_sequencer.sv
// Elevator door state machine: open, hold, close and reverse-on-obstruction,
// timed by a prescaled door tick.
//
// Optional feature macro: DOOR_NUDGE_EN. When defined, a closing stroke that
// starts with reopen_cnt >= MAX_REOPEN runs in nudge mode: slow (half-rate)
// closing that only weight_limit_exceeded can reverse. When undefined, nudge
// is tied low and no nudge logic exists.
//
// Ports:
//   clk                   in   system clock
//   button_reset          in   asynchronous, active-high reset
//   open_req              in   level; request open or extend hold
//   close_req             in   level; request early close
//   move_handler          in   car moving; keeps the door CLOSED
//   weight_limit_exceeded in   overload; blocks closing
//   obstruction           in   door-edge sensor
//   door_state[1:0]       out  0=CLOSED 1=OPENING 2=OPEN 3=CLOSING
//   door_closed           out  state is CLOSED
//   door_open             out  state is OPEN
//   closed_pulse          out  one cycle after CLOSING->CLOSED
//   reopen_cnt[3:0]       out  reversals since last CLOSED, saturating
//   nudge                 out  nudge mode active
module door_sequencer
    import door_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 4,
    parameter int unsigned MOVE_TIME  = 3,
    parameter int unsigned HOLD_TIME  = 5,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned MAX_REOPEN = 3
) (
    input  logic                clk,
    input  logic                button_reset,
    input  logic                open_req,
    input  logic                close_req,
    input  logic                move_handler,
    input  logic                weight_limit_exceeded,
    input  logic                obstruction,
    output logic [1:0]          door_state,
    output logic                door_closed,
    output logic                door_open,
    output logic                closed_pulse,
    output logic [REOPEN_W-1:0] reopen_cnt,
    output logic                nudge
);

    // Elaboration-time parameter sanity.
    if (TICK_DIV < 1 || MOVE_TIME < 1 || HOLD_TIME < 1 ||
        MOVE_TIME > (2 ** CNT_W) || HOLD_TIME > (2 ** CNT_W) ||
        MAX_REOPEN > (2 ** REOPEN_W) - 1) begin : g_bad_param
        $error("door_sequencer: illegal parameter combination");
    end

    localparam logic [CNT_W-1:0]    MoveLast  = CNT_W'(MOVE_TIME - 1);
    localparam logic [CNT_W-1:0]    HoldLast  = CNT_W'(HOLD_TIME - 1);
    localparam logic [REOPEN_W-1:0] ReopenSat = '1;

    door_state_t          state_q, state_d;
    logic [CNT_W-1:0]     timer_q, timer_d;
    logic [REOPEN_W-1:0]  reopen_q, reopen_d;
    logic                 pulse_q, pulse_d;
    logic                 tick;
    logic                 enter_closing;
    logic                 reverse;   // CLOSING must turn round this cycle
    logic                 close_step; // CLOSING timer may advance this cycle

    door_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk          (clk),
        .button_reset (button_reset),
        .tick_o       (tick)
    );

`ifdef DOOR_NUDGE_EN
    localparam logic [REOPEN_W-1:0] NudgeThresh = REOPEN_W'(MAX_REOPEN);

    logic nudge_q, nudge_d;
    logic phase_q, phase_d; // nudge closing advances on every second tick

    assign reverse    = nudge_q ? weight_limit_exceeded
                                : (weight_limit_exceeded || obstruction || open_req);
    assign close_step = tick && (!nudge_q || phase_q);

    always_comb begin
        nudge_d = nudge_q;
        phase_d = phase_q;
        if (enter_closing) begin
            nudge_d = (reopen_q >= NudgeThresh);
            phase_d = 1'b0;
        end else if (state_q == DOOR_CLOSING && nudge_q && tick) begin
            phase_d = ~phase_q;
        end
        if (state_d == DOOR_CLOSED) begin
            nudge_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge button_reset) begin
        if (button_reset) begin
            nudge_q <= 1'b0;
            phase_q <= 1'b0;
        end else begin
            nudge_q <= nudge_d;
            phase_q <= phase_d;
        end
    end

    assign nudge = nudge_q;
`else
    assign reverse    = weight_limit_exceeded || obstruction || open_req;
    assign close_step = tick;
    assign nudge      = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        reopen_d      = reopen_q;
        pulse_d       = 1'b0;
        enter_closing = 1'b0;
        unique case (state_q)
            DOOR_CLOSED: begin
                if (open_req && !move_handler) begin
                    state_d = DOOR_OPENING;
                    timer_d = '0;
                end
            end
            DOOR_OPENING: begin
                if (tick) begin
                    if (timer_q == MoveLast) begin
                        state_d = DOOR_OPEN;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + CNT_W'(1);
                    end
                end
            end
            DOOR_OPEN: begin
                if (weight_limit_exceeded || obstruction || open_req) begin
                    timer_d = '0;
                end else if (close_req || (tick && timer_q == HoldLast)) begin
                    state_d       = DOOR_CLOSING;
                    timer_d       = '0;
                    enter_closing = 1'b1;
                end else if (tick) begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
            DOOR_CLOSING: begin
                if (reverse) begin
                    // Reopen stroke equals the distance already closed.
                    state_d = DOOR_OPENING;
                    timer_d = MoveLast - timer_q;
                    if (reopen_q != ReopenSat) begin
                        reopen_d = reopen_q + REOPEN_W'(1);
                    end
                end else if (close_step) begin
                    if (timer_q == MoveLast) begin
                        state_d  = DOOR_CLOSED;
                        timer_d  = '0;
                        pulse_d  = 1'b1;
                        reopen_d = '0;
                    end else begin
                        timer_d = timer_q + CNT_W'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge button_reset) begin
        if (button_reset) begin
            state_q  <= DOOR_CLOSED;
            timer_q  <= '0;
            reopen_q <= '0;
            pulse_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            reopen_q <= reopen_d;
            pulse_q  <= pulse_d;
        end
    end

    assign door_state   = state_q;
    assign door_closed  = (state_q == DOOR_CLOSED);
    assign door_open    = (state_q == DOOR_OPEN);
    assign closed_pulse = pulse_q;
    assign reopen_cnt   = reopen_q;

endmodule

// File: tb/tb_door_sequencer.sv
// Scoreboard bench for door_sequencer: two instances (TICK_DIV=4 and 1) share
// stimulus; a behavioural door model predicts each cycle's outputs, which a
// separate monitor compares.
module tb_door_sequencer;

    localparam int TD = 4;
    localparam int MT = 3;
    localparam int HT = 5;
    localparam int MR = 3;
`ifdef DOOR_NUDGE_EN
    localparam bit NUDGE_ON = 1'b1;
`else
    localparam bit NUDGE_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic button_reset = 1'b0;
    logic open_req = 1'b0, close_req = 1'b0, move_handler = 1'b0;
    logic weight_limit_exceeded = 1'b0, obstruction = 1'b0;

    logic [1:0] ds0, ds1;
    logic       dc0, dc1, do0, do1, cp0, cp1, nu0, nu1;
    logic [3:0] rc0, rc1;

    door_sequencer #(.TICK_DIV(TD), .MOVE_TIME(MT), .HOLD_TIME(HT), .CNT_W(16),
                     .MAX_REOPEN(MR)) dut0 (
        .clk(clk), .button_reset(button_reset), .open_req(open_req),
        .close_req(close_req), .move_handler(move_handler),
        .weight_limit_exceeded(weight_limit_exceeded), .obstruction(obstruction),
        .door_state(ds0), .door_closed(dc0), .door_open(do0), .closed_pulse(cp0),
        .reopen_cnt(rc0), .nudge(nu0));

    door_sequencer #(.TICK_DIV(1), .MOVE_TIME(MT), .HOLD_TIME(HT), .CNT_W(16),
                     .MAX_REOPEN(MR)) dut1 (
        .clk(clk), .button_reset(button_reset), .open_req(open_req),
        .close_req(close_req), .move_handler(move_handler),
        .weight_limit_exceeded(weight_limit_exceeded), .obstruction(obstruction),
        .door_state(ds1), .door_closed(dc1), .door_open(do1), .closed_pulse(cp1),
        .reopen_cnt(rc1), .nudge(nu1));

    always #5 clk = ~clk;

    // Door model: st 0..3 as on door_state; t = ticks into opening/hold;
    // q = ticks spent in the current closing stroke; n = clocks since reset.
    typedef struct {
        int st; int t; int q; int reop; bit pulse; bit nudge; int n;
    } mdl_t;

    mdl_t m0, m1;
    mdl_t exp0_q[$];
    mdl_t exp1_q[$];
    int n_cmp = 0, n_bad = 0, pulse_seen = 0;

    function automatic mdl_t mreset();
        mdl_t r;
        r.st = 0; r.t = 0; r.q = 0; r.reop = 0; r.pulse = 0; r.nudge = 0; r.n = 0;
        return r;
    endfunction

    function automatic mdl_t mstep(mdl_t m, bit o, bit c, bit mv, bit w, bit ob, int div);
        mdl_t r = m;
        bit   tick = (m.n % div) == div - 1;
        int   k = m.nudge ? 2 : 1; // nudge closing is twice as slow
        r.n = m.n + 1;
        r.pulse = 0;
        case (m.st)
            0: if (o && !mv) begin r.st = 1; r.t = 0; end
            1: if (tick) begin
                   if (m.t + 1 >= MT) begin r.st = 2; r.t = 0; end
                   else r.t = m.t + 1;
               end
            2: if (w || ob || o) r.t = 0;
               else if (c || (tick && m.t + 1 >= HT)) begin
                   r.st = 3; r.q = 0; r.nudge = NUDGE_ON && (m.reop >= MR);
               end else if (tick) r.t = m.t + 1;
            default:
               if (w || (!m.nudge && (ob || o))) begin
                   r.st = 1; r.t = (MT - 1) - m.q / k;
                   r.reop = (m.reop < 15) ? m.reop + 1 : 15;
               end else if (tick) begin
                   if (m.q + 1 >= MT * k) begin
                       r.st = 0; r.pulse = 1; r.reop = 0; r.nudge = 0;
                   end else r.q = m.q + 1;
               end
        endcase
        return r;
    endfunction

    task automatic check(input string name, input int act, input int expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: pops one expectation per clock and compares both instances.
    always @(posedge clk) begin
        #1;
        if (cp0 === 1'b1) pulse_seen++;
        if (exp0_q.size() > 0) begin
            mdl_t e0, e1;
            e0 = exp0_q.pop_front();
            e1 = exp1_q.pop_front();
            check("d0_state", int'(ds0), e0.st);
            check("d0_closed", int'(dc0), int'(e0.st == 0));
            check("d0_open", int'(do0), int'(e0.st == 2));
            check("d0_pulse", int'(cp0), int'(e0.pulse));
            check("d0_reopen", int'(rc0), e0.reop);
            check("d0_nudge", int'(nu0), int'(e0.nudge));
            check("d1_state", int'(ds1), e1.st);
            check("d1_pulse", int'(cp1), int'(e1.pulse));
            check("d1_reopen", int'(rc1), e1.reop);
        end
    end

    // All stimulus tasks start and end just after a falling edge.
    task automatic step(input bit o, input bit c, input bit mv, input bit w, input bit ob);
        open_req = o; close_req = c; move_handler = mv;
        weight_limit_exceeded = w; obstruction = ob;
        m0 = mstep(m0, o, c, mv, w, ob, TD);
        m1 = mstep(m1, o, c, mv, w, ob, 1);
        exp0_q.push_back(m0);
        exp1_q.push_back(m1);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(0, 0, 0, 0, 0);
    endtask

    // Asynchronous reset away from any clock edge; outputs must clear at once.
    task automatic do_reset();
        #1 button_reset = 1'b1;
        #1;
        check("rst_d0_state", int'(ds0), 0);
        check("rst_d0_closed", int'(dc0), 1);
        check("rst_d0_open", int'(do0), 0);
        check("rst_d0_pulse", int'(cp0), 0);
        check("rst_d0_reopen", int'(rc0), 0);
        check("rst_d0_nudge", int'(nu0), 0);
        check("rst_d1_state", int'(ds1), 0);
        check("rst_d1_reopen", int'(rc1), 0);
        @(negedge clk);
        button_reset = 1'b0;
        m0 = mreset();
        m1 = mreset();
    endtask

    // Run idle until the chosen model reaches state st (and closing progress
    // q, if q >= 0), within a cycle budget.
    task automatic wait_state(input int which, input int st, input int q, input int budget);
        for (int i = 0; i < budget; i++) begin
            mdl_t m;
            m = (which == 0) ? m0 : m1;
            if (m.st == st && (q < 0 || m.q == q)) return;
            idle(1);
        end
        n_cmp++;
        n_bad++;
        $display("FAIL wait_state: model %0d never reached state %0d, expected within %0d",
                 which, st, budget);
    endtask

    initial begin
        int p0;
        m0 = mreset();
        m1 = mreset();
        do_reset();

        // Full cycle from a single open_req.
        p0 = pulse_seen;
        step(1, 0, 0, 0, 0);
        idle(60);
        check("t1_pulse_count", pulse_seen - p0, 1);
        check("t1_closed_end", int'(dc0), 1);

        // Car moving holds the door closed; release opens next cycle.
        for (int i = 0; i < 40; i++) step(1, 0, 1, 0, 0);
        check("t2_held_closed", int'(ds0), 0);
        step(1, 0, 0, 0, 0);
        check("t2_opening", int'(ds0), 1);
        idle(60);

        // Obstruction one tick into CLOSING, then a clean close.
        step(1, 0, 0, 0, 0);
        wait_state(0, 3, 1, 100);
        step(0, 0, 0, 0, 1);
        check("t3_reopen1", int'(rc0), 1);
        idle(80);
        check("t3_reopen_cleared", int'(rc0), 0);

        // Overload in OPEN for 30 ticks, then early close_req.
        step(1, 0, 0, 0, 0);
        wait_state(0, 2, -1, 40);
        for (int i = 0; i < 30 * TD; i++) step(0, 0, 0, 1, 0);
        check("t4_still_open", int'(ds0), 2);
        wait_state(0, 3, -1, 40);
        step(1, 0, 0, 0, 0);
        wait_state(0, 2, -1, 40);
        step(0, 1, 0, 0, 0);
        check("t4_close_req", int'(ds0), 3);

        // Asynchronous reset mid-CLOSING, on each instance.
        wait_state(0, 3, 1, 20);
        do_reset();
        step(1, 0, 0, 0, 0);
        wait_state(1, 3, 1, 40);
        do_reset();

        // Repeated reversals.
        step(1, 0, 0, 0, 0);
        for (int r = 0; r < 4; r++) begin
            wait_state(0, 3, 0, 100);
            idle(2);
            step(0, 0, 0, 0, 1);
        end
        check("t6_reopen", int'(rc0), NUDGE_ON ? MR : 4);
        idle(100);

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) do_reset();
            step($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 11) == 0);
        end
        idle(2);

        check("queue_drained", exp0_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/door_sequencer.md
Name: door_sequencer

Overview:
- Parametrised successor to the door-timing divider in the elevator car datapath.
- Replaces a free-toggling door clock with a full door state machine: open, hold, close, and reverse-on-obstruction.
- Timing is derived from an internal prescaled tick.
- Sits between the floor/move controller (open_req, close_req, move_handler) and the door actuator and status logic.

Parameters:
- TICK_DIV, 4: clk cycles per door tick; must be >= 1.
- MOVE_TIME, 3: ticks for a full open or close stroke; must be >= 1.
- HOLD_TIME, 5: ticks the door stays open with no activity; must be >= 1.
- CNT_W, 16: width of the tick timer; MOVE_TIME and HOLD_TIME must fit.
- MAX_REOPEN, 3: reversals before nudge mode; used only with DOOR_NUDGE_EN.

Ports:
- clk  in  1  system clock
- button_reset  in  1  asynchronous, active-high reset
- open_req  in  1  level; request open or extend hold
- close_req  in  1  level; request early close
- move_handler  in  1  car moving; inhibits leaving CLOSED
- weight_limit_exceeded  in  1  overload; blocks closing
- obstruction  in  1  door-edge sensor
- door_state  out  2  0=CLOSED, 1=OPENING, 2=OPEN, 3=CLOSING
- door_closed  out  1  state==CLOSED
- door_open  out  1  state==OPEN
- closed_pulse  out  1  one-cycle pulse on CLOSING->CLOSED
- reopen_cnt  out  4  reversals since last CLOSED, saturating at 15
- nudge  out  1  nudge mode active

Behaviour:
- Reset: the async button_reset drives all registers to the reset state.
  - state=CLOSED, timer=0, prescaler=0.
  - closed_pulse=0, reopen_cnt=0, nudge=0.
  - door_closed=1, door_open=0.
  - Reset mid-stroke returns immediately to CLOSED; no pulse is emitted.
- Prescaler:
  - Free-running counter 0..TICK_DIV-1.
  - tick=1 for one cycle when the count equals TICK_DIV-1, after which it wraps to 0.
  - TICK_DIV=1 gives tick every cycle.
- Timer:
  - CNT_W bits; advances only on tick.
  - Any state transition loads the timer per the rules below in that cycle, regardless of tick.
- CLOSED:
  - If open_req && !move_handler, go to OPENING with timer=0.
  - move_handler=1 holds CLOSED.
- OPENING:
  - Each tick increments the timer.
  - On a tick with timer==MOVE_TIME-1, go to OPEN with timer=0. OPENING therefore lasts exactly MOVE_TIME ticks.
  - All inputs are ignored in OPENING.
- OPEN, priority per cycle:
  1. weight_limit_exceeded || obstruction: timer held at 0.
  2. open_req: timer=0 (hold extension).
  3. close_req: go to CLOSING with timer=0.
  4. A tick with timer==HOLD_TIME-1: go to CLOSING with timer=0.
  5. Otherwise a tick increments the timer.
- CLOSING:
  - Reversal: if obstruction || weight_limit_exceeded || open_req, go to OPENING with timer=(MOVE_TIME-1)-timer. The reopen stroke equals the distance already closed. reopen_cnt increments, saturating.
  - Completion: otherwise, on a tick with timer==MOVE_TIME-1, go to CLOSED. closed_pulse=1 for the next cycle only, and reopen_cnt clears.
  - Otherwise a tick increments the timer.
- move_handler has no effect outside CLOSED. Interlocking the drive on door_closed is the consumer's job.
- Outputs are registered or decoded directly from the state register; there is no combinational path from inputs to outputs.

Optional Feature:
- Macro DOOR_NUDGE_EN.
- Defined:
  - When reopen_cnt >= MAX_REOPEN on entry to CLOSING, nudge=1.
  - In nudge mode, CLOSING ignores obstruction and open_req; only weight_limit_exceeded reverses the door.
  - Each nudge closing stroke takes 2*MOVE_TIME ticks, with the timer advancing on every second tick.
  - nudge clears on CLOSED or reset.
- Undefined: nudge is tied to 0 and no nudge logic is synthesised; reversal rules apply unconditionally.

Decomposition:
- Package door_pkg:
  - door_state_t 2-bit encoding constants: DOOR_CLOSED, DOOR_OPENING, DOOR_OPEN, DOOR_CLOSING.
  - REOPEN_W=4.
- Sub-module door_tick_gen:
  - Parametrised prescaler with clk, button_reset, and a single-cycle tick output.
  - Reusable by other timed blocks.

Test Plan (TICK_DIV=4, MOVE_TIME=3, HOLD_TIME=5 unless noted):
1. Reset, then one-cycle open_req → OPENING for exactly 3 ticks, OPEN for 5 ticks, CLOSING for 3 ticks, then CLOSED. closed_pulse is high for exactly 1 cycle; door_closed=1 at end.
2. open_req with move_handler=1 for 40 cycles → state stays CLOSED. Releasing move_handler while open_req is held → OPENING the next cycle.
3. obstruction asserted after 1 tick of CLOSING → OPENING with timer=1; OPEN reached after 2 ticks; reopen_cnt=1. A later clean close clears reopen_cnt to 0.
4. In OPEN, weight_limit_exceeded held for 30 ticks → state stays OPEN. After release, CLOSING follows exactly 5 ticks later. close_req in OPEN with no blockers → CLOSING the next cycle.
5. button_reset asserted asynchronously mid-CLOSING → door_state=0 and reopen_cnt=0 immediately, no closed_pulse. Same check with TICK_DIV=1.
6. DOOR_NUDGE_EN defined: 3 obstruction reversals → next CLOSING has nudge=1, ignores obstruction, and completes in 6 ticks. With the macro undefined, the same stimulus reverses a 4th time and reopen_cnt=4.
